mux16_serializer: RTL

Sequential controller that sits directly upstream of the `mux16` 16:1 multiplexer and drives its data and select inputs. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data bus. It then steps the 4-bit select through all 16 positions and returns the mux output as a serial bit stream with its own valid/ready handshake. `mux16` remains purely combinational; this block supplies all sequencing.

---
 rtl/mux16_serializer.sv | 79 +++++++
 1 files changed

// File: rtl/mux16_serializer.sv
// mux16_serializer: loads a 16-bit word, steps the mux16 select and streams mux_y out as serial beats (MUX16_SER_PARITY_EN adds a parity beat; ports: clk, rst, in_* load handshake, mux_a/mux_s/mux_y mux link, ser_* serial handshake, busy)
module mux16_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mux_a,
  output logic [3:0]  mux_s,
  input  logic        mux_y,
  output logic        ser_bit,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_last,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2;
  localparam logic [3:0] S_START = MSB_FIRST ? 4'hf : 4'h0;
  localparam logic [3:0] S_END = MSB_FIRST ? 4'h0 : 4'hf;
  logic [1:0] state_q, state_d;
  logic [15:0] mux_a_q, mux_a_d;
  logic [3:0] mux_s_q, mux_s_d;
  logic at_end, load, accept;
  assign at_end = mux_s_q == S_END;
  assign mux_a = mux_a_q;
  assign mux_s = mux_s_q;
  assign ser_valid = state_q != IDLE;
  assign busy = state_q != IDLE;
  assign in_ready = !rst && (state_q == IDLE || (ser_last && ser_ready));
  assign load = in_valid && in_ready;
  assign accept = ser_valid && ser_ready;
`ifdef MUX16_SER_PARITY_EN
  logic par_q, par_d;
  assign ser_last = state_q == PARITY;
  assign ser_bit = state_q == PARITY ? par_q : mux_y;
`else
  assign ser_last = state_q == SHIFT && at_end;
  assign ser_bit = mux_y;
`endif
  always_comb begin
    state_d = state_q;
    mux_a_d = mux_a_q;
    mux_s_d = mux_s_q;
`ifdef MUX16_SER_PARITY_EN
    par_d = par_q;
    if (accept && state_q == SHIFT && at_end) state_d = PARITY;
`endif
    if (accept && state_q == SHIFT && !at_end) mux_s_d = MSB_FIRST ? mux_s_q - 4'd1 : mux_s_q + 4'd1;
    if (accept && ser_last) state_d = IDLE;
    // a load on the final-beat edge overrides the return to IDLE
    if (load) begin
      state_d = SHIFT;
      mux_a_d = in_data;
      mux_s_d = S_START;
`ifdef MUX16_SER_PARITY_EN
      par_d = ^in_data;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mux_a_q <= 16'h0000;
      mux_s_q <= 4'h0;
`ifdef MUX16_SER_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mux_a_q <= mux_a_d;
      mux_s_q <= mux_s_d;
`ifdef MUX16_SER_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
endmodule
